asm_seq_ctrl: RTL and testbench
===============================

ASM_SEQ_CTRL -- requirements
Module: asm_seq_ctrl

Interface
REQ-001 Parameter: N, default 4, operand width in bits; product width is 2N.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request to multiply A by B; sampled only in IDLE.
REQ-005 A  input  N  multiplicand (unsigned).
REQ-006 B  input  N  multiplier (unsigned).
REQ-007 busy  output  1  high while a multiplication is in progress (CALC state).
REQ-008 done  output  1  one-cycle pulse marking that O holds a new product.
REQ-009 O  output  2N  registered unsigned product A*B.

Function
REQ-010 The block SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-011 IDLE: on a rising edge with start=1, A SHALL be latched into M, B into Q, accumulator P cleared, step counter cleared, and next state CALC; with start=0, state holds.
REQ-012 A and B SHALL be sampled only at the accepting edge; later changes to A or B SHALL NOT affect the result.
REQ-013 CALC: each edge performs one add-shift step: if Q[0]=1, {C,P} = P + M (N+1 bits), else {C,P} = {0,P}; then {C,P,Q} is shifted right by one, and the counter increments.
REQ-014 CALC SHALL last exactly N edges; on the N-th step edge the full value {P,Q} SHALL be written to O and the FSM SHALL enter DONE.
REQ-015 Latency: done SHALL be high during the cycle following the N-th rising edge after the accepting edge, i.e. N cycles after start is accepted.
REQ-016 DONE: done=1 for exactly one cycle; the next edge SHALL return the FSM to IDLE unconditionally.
REQ-017 start SHALL be ignored in CALC and DONE; a request held high SHALL be accepted on the first edge in IDLE (the edge after DONE), giving a minimum issue interval of N+2 cycles.
REQ-018 busy SHALL equal 1 exactly while in CALC; busy and done SHALL never be high together.
REQ-019 O SHALL hold its value from the DONE-entry edge until the next DONE-entry edge; it SHALL NOT show intermediate partial products.
REQ-020 Arithmetic SHALL be unsigned with no overflow: max result (2^N-1)^2 fits in 2N bits; carry C SHALL be retained between steps.
REQ-021 Zero operands (A=0 or B=0) SHALL take the same N-step latency and yield O=0.

Reset
REQ-022 When rst=1, regardless of clk, the FSM SHALL enter IDLE and busy=0, done=0, O=0, M=0, Q=0, P=0, counter=0.
REQ-023 Reset asserted mid-CALC SHALL abort the operation; no done pulse SHALL be produced for the aborted operation and O SHALL read 0.
REQ-024 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-025 A=5, B=3, start pulsed one cycle -> busy high 4 cycles, then done one cycle with O=8'h0F; O stays 8'h0F afterward.
REQ-026 A=15, B=15 -> O=8'hE1 (225) with done exactly 4 cycles after acceptance; A=0, B=9 -> O=8'h00 with identical latency.
REQ-027 Accept A=6, B=7, then change A/B to 2/2 and pulse start during CALC -> change and pulse ignored; O=8'h2A (42); no second done.
REQ-028 start held high continuously with A=3, B=4 -> done pulses every 6 cycles (N+2), O=8'h0C each time, busy low in DONE and IDLE cycles.
REQ-029 Accept A=9, B=9, assert rst asynchronously (between edges) after 2 CALC cycles -> busy, done, O go 0 immediately; after release, A=2, B=3 -> O=8'h06 after 4 cycles.

Source files
------------

// File: rtl/asm_seq_ctrl.sv
// asm_seq_ctrl: sequential add-shift unsigned multiplier.
// A start in IDLE latches the operands. CALC then runs N add-shift steps.
// The full product is written to O on the last step, and DONE raises a
// one-cycle done pulse before the FSM returns to IDLE.
module asm_seq_ctrl #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] O
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [N-1:0]    m;
    logic [N-1:0]    q;
    logic [N-1:0]    p;
    logic [CW-1:0]   cnt;
    logic [2*N-1:0]  step_pq;

    // One add-shift step.
    // The N+1-bit sum keeps the carry, and the right shift moves that carry
    // into the top of P. The result is the new {P,Q}.
    function automatic logic [2*N-1:0] add_shift(
        input logic [N-1:0] p_in,
        input logic [N-1:0] q_in,
        input logic [N-1:0] m_in
    );
        logic [N:0] sum;
        sum = {1'b0, p_in} + (q_in[0] ? {1'b0, m_in} : {(N+1){1'b0}});
        return {sum, q_in[N-1:1]};
    endfunction

    assign step_pq = add_shift(p, q, m);

    // Control FSM and datapath.
    // All outputs are registered; reset clears the whole block at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            O     <= '0;
            m     <= '0;
            q     <= '0;
            p     <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        m     <= A;
                        q     <= B;
                        p     <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    p   <= step_pq[2*N-1:N];
                    q   <= step_pq[N-1:0];
                    cnt <= cnt + CW'(1);
                    // The last step publishes the product directly, so O never
                    // exposes a partial product.
                    if (cnt == CW'(N - 1)) begin
                        O     <= step_pq;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_asm_seq_ctrl.sv
// Directed testbench for asm_seq_ctrl with N=4.
// Inputs change 1 ns after a rising edge, and outputs are checked at that
// same point.
module tb_asm_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic       busy;
    logic       done;
    logic [7:0] O;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_o;

    asm_seq_ctrl #(.N(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .O     (O)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one multiplication from IDLE with a single-cycle start pulse.
    // Busy must be high for 4 cycles and O must stay unchanged meanwhile.
    // Done then pulses once with the product, and the FSM returns to IDLE.
    task automatic run_mul(input logic [3:0] a, input logic [3:0] b, input logic [7:0] prod);
        A     = a;
        B     = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_c0", 16'(busy), 16'd1);
        check("done_c0", 16'(done), 16'd0);
        for (int i = 1; i < 4; i++) begin
            tick();
            check("busy_calc", 16'(busy), 16'd1);
            check("done_calc", 16'(done), 16'd0);
            check("o_hold_calc", 16'(O), 16'(exp_o));
        end
        tick();
        check("done_pulse", 16'(done), 16'd1);
        check("busy_in_done", 16'(busy), 16'd0);
        check("o_product", 16'(O), 16'(prod));
        exp_o = prod;
        tick();
        check("done_clear", 16'(done), 16'd0);
        check("busy_idle", 16'(busy), 16'd0);
        check("o_hold_idle", 16'(O), 16'(prod));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        A     = 4'd0;
        B     = 4'd0;
        exp_o = 8'h00;
        tick();
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        check("rst_o", 16'(O), 16'h00);
        rst = 1'b0;
        tick();
        check("idle_busy", 16'(busy), 16'd0);

        // 5*3
        run_mul(4'd5, 4'd3, 8'h0F);
        tick();
        check("o_stays_0f", 16'(O), 16'h0F);

        // Maximum operands, then zero operands with the same latency.
        run_mul(4'd15, 4'd15, 8'hE1);
        run_mul(4'd0, 4'd9, 8'h00);
        run_mul(4'd9, 4'd0, 8'h00);

        // Operand changes and a start pulse during CALC are both ignored.
        A     = 4'd6;
        B     = 4'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_busy0", 16'(busy), 16'd1);
        A     = 4'd2;
        B     = 4'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_busy1", 16'(busy), 16'd1);
        tick();
        tick();
        check("ign_busy3", 16'(busy), 16'd1);
        tick();
        check("ign_done", 16'(done), 16'd1);
        check("ign_o", 16'(O), 16'h2A);
        exp_o = 8'h2A;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("ign_no_second_done", 16'(done), 16'd0);
            check("ign_no_busy", 16'(busy), 16'd0);
        end
        check("ign_o_hold", 16'(O), 16'h2A);

        // Start held high: a new issue every N+2 = 6 cycles.
        A     = 4'd3;
        B     = 4'd4;
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bb_busy_acc", 16'(busy), 16'd1);
            check("bb_done_acc", 16'(done), 16'd0);
            for (int i = 1; i < 4; i++) begin
                tick();
                check("bb_busy_calc", 16'(busy), 16'd1);
            end
            tick();
            check("bb_done", 16'(done), 16'd1);
            check("bb_busy_done", 16'(busy), 16'd0);
            check("bb_o", 16'(O), 16'h0C);
            if (k == 2) start = 1'b0;
            tick();
            check("bb_done_idle", 16'(done), 16'd0);
            check("bb_busy_idle", 16'(busy), 16'd0);
        end
        exp_o = 8'h0C;
        tick();
        check("bb_stopped", 16'(busy), 16'd0);

        // Asynchronous reset in mid-CALC aborts the operation.
        A     = 4'd9;
        B     = 4'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("ar_busy_pre", 16'(busy), 16'd1);
        #3;
        rst = 1'b1;
        #1;
        check("ar_busy", 16'(busy), 16'd0);
        check("ar_done", 16'(done), 16'd0);
        check("ar_o", 16'(O), 16'h00);
        #1;
        rst = 1'b0;
        exp_o = 8'h00;
        tick();
        check("ar_no_done", 16'(done), 16'd0);
        check("ar_o_after", 16'(O), 16'h00);
        run_mul(4'd2, 4'd3, 8'h06);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
